// File: rtl/mux6_bus_arbiter.sv
// mux6_bus_arbiter: arbiter for the six-input 16-bit shared-bus mux; drives the mux select.
// Define ARB_ROUND_ROBIN_EN for pointer-based round-robin, otherwise fixed priority (lowest index wins).
`default_nettype none

module mux6_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [5:0] req_i,
  output logic [5:0] gnt_o,
  output logic [2:0] s_o,
  output logic       bus_valid_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic [1:0] state_q, state_d;
  logic [5:0] gnt_q, gnt_d;
  logic [2:0] s_q, s_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] ptr;
  logic       win_found;
  logic [2:0] win_idx;
  logic       hold_ok;

  // Owner keeps the bus only while it still requests and has hold budget left.
  assign hold_ok = req_i[s_q] && (cnt_q < HOLD_MAX);

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_GRANT && !hold_ok) begin
      ptr_d = (s_q == 3'd5) ? 3'd0 : s_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 3'd0;
`endif

  // Search upward from the pointer, wrapping 5 -> 0.
  always_comb begin
    logic [3:0] cand;
    cand      = 4'd0;
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = 0; i < 6; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'd6) begin
        cand = cand - 4'd6;
      end
      if (!win_found && req_i[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (win_found) begin
          state_d = ST_GRANT;
          gnt_d   = 6'b000001 << win_idx;
          s_d     = win_idx;
          cnt_d   = 4'd1;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = 6'b000000;
        end
      end
      ST_GRANT: begin
        if (hold_ok) begin
          cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end else begin
          state_d = ST_GAP;
          gnt_d   = 6'b000000;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 6'b000000;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= 6'b000000;
      s_q     <= 3'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign s_o         = s_q;
  assign bus_valid_o = |gnt_q;

endmodule

`default_nettype wire
